vec_sequencer: RTL and testbench
================================

VEC_SEQUENCER -- requirements
Module: vec_sequencer

Interface
REQ-001 Parameter VLEN_W, default 4, sets the width of the vector-length field and element index; element count is vlen+1, giving 1..2^VLEN_W elements.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  sequencer can accept an instruction.
REQ-006 op_code  input  3  opcode, sampled on accept.
REQ-007 vlen  input  VLEN_W  element count minus one, sampled on accept.
REQ-008 stall  input  1  datapath/memory not ready; freezes execution.
REQ-009 elem_idx  output  VLEN_W  current element index.
REQ-010 we_a_reg, we_b_reg, we_mem  output  1 each  datapath write enables.
REQ-011 mux0, mux1, mux2  output  1 each  datapath select lines.
REQ-012 busy  output  1  instruction in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  qualifies done; illegal opcode.

Function
REQ-015 States SHALL be IDLE, EXEC, FIN; an instruction is accepted when instr_valid and instr_ready are both high.
REQ-016 instr_ready SHALL be high only in IDLE.
REQ-017 On accept, op_code and vlen SHALL be registered, elem_idx SHALL be 0, and the state SHALL move to EXEC.
REQ-018 In EXEC with stall low, decoded enables SHALL assert for exactly one cycle per element; elem_idx increments, and on elem_idx==vlen the state SHALL move to FIN.
REQ-019 In EXEC with stall high, all write enables SHALL be 0, and elem_idx and state SHALL hold; mux lines SHALL hold decoded values.
REQ-020 Decode SHALL be (we_a,we_b,we_mem,mux0,mux1,mux2): 000,001,110 -> 1,0,0,0,0,1; 100 -> 0,1,0,0,1,0; 101 -> 0,0,1,1,1,0; 111 -> 1,0,0,0,0,0.
REQ-021 Opcodes 010 and 011 SHALL be accepted, skip EXEC, go directly to FIN with all enables 0, and assert err with done.
REQ-022 In FIN, done SHALL be high for one cycle, and the state SHALL return to IDLE; err SHALL be 0 whenever done is 0.
REQ-023 Latency for a legal opcode without stalls SHALL be vlen+2 cycles from accept to done; a new accept is possible the cycle after done.
REQ-024 busy SHALL be high in EXEC and FIN.
REQ-025 Outside EXEC, all write enables and mux lines SHALL be 0.
REQ-026 elem_idx at maximum (all ones) SHALL terminate the instruction and SHALL NOT wrap into further writes.

Reset
REQ-027 rst SHALL force IDLE; elem_idx, all enables, muxes, busy, done and err SHALL be 0, and instr_ready SHALL be 1 in the following cycle.
REQ-028 rst asserted mid-EXEC SHALL abort the instruction without a done pulse.

Configuration
REQ-029 With VSEQ_PERF_EN defined, output instr_count (16 bits) SHALL count done pulses with err low, wrapping at 0xFFFF->0 and cleared by rst; without it, the port and counter SHALL be absent.

Structure
REQ-030 Package vseq_pkg SHALL hold the opcode constants, the state enumeration, and the packed decode-control type.
REQ-031 The opcode-to-control table SHALL be a combinational sub-module vseq_decode; the FSM and counter stay in vec_sequencer.

Verification
REQ-032 op 000, vlen 3, no stall: we_a_reg and mux2 high for 4 cycles, elem_idx 0..3, done at accept+5.
REQ-033 op 101, vlen 2, stall high for 2 cycles at elem 1: we_mem pulses total 3, elem_idx holds at 1 during stall, done at accept+6.
REQ-034 op 011: no enables asserted, done and err high at accept+1, instr_ready high at accept+2.
REQ-035 op 100, vlen 15: 16 we_b_reg pulses, elem_idx reaches 15, no 17th write.
REQ-036 rst at EXEC element 2 of op 111 vlen 7: next cycle IDLE, no done, all outputs 0, instr_ready 1.
REQ-037 VSEQ_PERF_EN build: 3 legal and 1 illegal instruction -> instr_count == 3.

Source files
------------

// File: rtl/vseq_pkg.sv
// Shared definitions for the vector sequencer: opcodes, FSM states, decode controls.
package vseq_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_A0   = 3'b000;
  localparam logic [OP_W-1:0] OP_A1   = 3'b001;
  localparam logic [OP_W-1:0] OP_ILL0 = 3'b010;
  localparam logic [OP_W-1:0] OP_ILL1 = 3'b011;
  localparam logic [OP_W-1:0] OP_B    = 3'b100;
  localparam logic [OP_W-1:0] OP_MEM  = 3'b101;
  localparam logic [OP_W-1:0] OP_A2   = 3'b110;
  localparam logic [OP_W-1:0] OP_A3   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  typedef struct packed {
    logic we_a;
    logic we_b;
    logic we_mem;
    logic mux0;
    logic mux1;
    logic mux2;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // Opcodes that are accepted but report an error instead of executing.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return (op == OP_ILL0) || (op == OP_ILL1);
  endfunction

endpackage

// File: rtl/vseq_decode.sv
// Opcode to datapath-control lookup; illegal opcodes decode to all zeros.
module vseq_decode
  import vseq_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t ctrl;

  // Fixed control table, fields ordered we_a, we_b, we_mem, mux0, mux1, mux2.
  always_comb begin
    ctrl = '0;
    case (op_i)
      OP_A0, OP_A1, OP_A2: ctrl = '{we_a: 1'b1, we_b: 1'b0, we_mem: 1'b0,
                                    mux0: 1'b0, mux1: 1'b0, mux2: 1'b1};
      OP_B:                ctrl = '{we_a: 1'b0, we_b: 1'b1, we_mem: 1'b0,
                                    mux0: 1'b0, mux1: 1'b1, mux2: 1'b0};
      OP_MEM:              ctrl = '{we_a: 1'b0, we_b: 1'b0, we_mem: 1'b1,
                                    mux0: 1'b1, mux1: 1'b1, mux2: 1'b0};
      OP_A3:               ctrl = '{we_a: 1'b1, we_b: 1'b0, we_mem: 1'b0,
                                    mux0: 1'b0, mux1: 1'b0, mux2: 1'b0};
      default:             ctrl = '0;
    endcase
    ctrl_o = ctrl;
  end

endmodule

// File: rtl/vec_sequencer.sv
// Vector instruction sequencer: steps one element per unstalled cycle and
// drives datapath enables. Optional done counter enabled by VSEQ_PERF_EN.
module vec_sequencer
  import vseq_pkg::*;
#(
  parameter int unsigned VLEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   op_code,
  input  logic [VLEN_W-1:0] vlen,
  input  logic              stall,
  output logic [VLEN_W-1:0] elem_idx,
  output logic              we_a_reg,
  output logic              we_b_reg,
  output logic              we_mem,
  output logic              mux0,
  output logic              mux1,
  output logic              mux2,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef VSEQ_PERF_EN
  ,
  output logic [15:0]       instr_count
`endif
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [VLEN_W-1:0]   vlen_q, vlen_d;
  logic [VLEN_W-1:0]   idx_q, idx_d;
  logic                err_q, err_d;
  logic [CTRL_W-1:0]   dec_bits;
  ctrl_t               dec;

  vseq_decode u_decode (
    .op_i   (op_q),
    .ctrl_o (dec_bits)
  );

  assign dec = ctrl_t'(dec_bits);

  // State and instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      vlen_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vlen_q  <= vlen_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept in IDLE, step elements in EXEC, single FIN cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vlen_d  = vlen_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d   = op_code;
          vlen_d = vlen;
          idx_d  = '0;
          err_d  = op_illegal(op_code);
          state_d = op_illegal(op_code) ? ST_FIN : ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Terminating on idx==vlen also stops at all-ones without wrapping.
        if (!stall) begin
          if (idx_q == vlen_q) begin
            state_d = ST_FIN;
          end else begin
            idx_d = idx_q + VLEN_W'(1);
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: enables gated by stall in EXEC, muxes hold decode while stalled.
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    we_a_reg    = 1'b0;
    we_b_reg    = 1'b0;
    we_mem      = 1'b0;
    mux0        = 1'b0;
    mux1        = 1'b0;
    mux2        = 1'b0;
    elem_idx    = idx_q;
    case (state_q)
      ST_IDLE: instr_ready = 1'b1;
      ST_EXEC: begin
        busy     = 1'b1;
        we_a_reg = dec.we_a   & ~stall;
        we_b_reg = dec.we_b   & ~stall;
        we_mem   = dec.we_mem & ~stall;
        mux0     = dec.mux0;
        mux1     = dec.mux1;
        mux2     = dec.mux2;
      end
      ST_FIN: begin
        busy = 1'b1;
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

`ifdef VSEQ_PERF_EN
  logic [15:0] cnt_q;

  // Count error-free completions; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if ((state_q == ST_FIN) && !err_q) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_vec_sequencer.sv
// Self-checking bench for vec_sequencer (covers VSEQ_PERF_EN when defined).
module tb_vec_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] op_code;
  logic [3:0] vlen;
  logic       stall;
  logic [3:0] elem_idx;
  logic       we_a_reg, we_b_reg, we_mem;
  logic       mux0, mux1, mux2;
  logic       busy, done, err;
`ifdef VSEQ_PERF_EN
  logic [15:0] instr_count;
`endif

  int total = 0;
  int bad = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  vec_sequencer #(.VLEN_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op_code     (op_code),
    .vlen        (vlen),
    .stall       (stall),
    .elem_idx    (elem_idx),
    .we_a_reg    (we_a_reg),
    .we_b_reg    (we_b_reg),
    .we_mem      (we_mem),
    .mux0        (mux0),
    .mux1        (mux1),
    .mux2        (mux2),
    .busy        (busy),
    .done        (done),
    .err         (err)
`ifdef VSEQ_PERF_EN
    ,
    .instr_count (instr_count)
`endif
  );

  // Reference control table {we_a, we_b, we_mem, mux0, mux1, mux2}.
  function automatic logic [5:0] ref_ctrl(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd6: return 6'b100001;
      3'd4:             return 6'b010010;
      3'd5:             return 6'b001110;
      3'd7:             return 6'b100000;
      default:          return 6'b000000;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [2:0] op);
    return !(op == 3'd2 || op == 3'd3);
  endfunction

  // One instruction from accept to done; stall either scheduled or random.
  task automatic run_instr(input string name, input logic [2:0] op, input logic [3:0] vl,
                           input int stall_pct, input int stall_at, input int stall_len,
                           output int done_cyc, output int wr_cnt, output int stall_cnt);
    logic [5:0]  c;
    logic        legal;
    logic        s;
    logic        fin;
    logic [13:0] got, expv, mask;
    int          elems;
    c = ref_ctrl(op);
    legal = ref_legal(op);
    elems = 0;
    stall_cnt = 0;
    done_cyc = -1;
    wr_cnt = 0;
    instr_valid = 1'b1;
    op_code = op;
    vlen = vl;
    stall = 1'($urandom);
    @(negedge clk);
    total++;
    if ({instr_ready, busy, done} !== 3'b100) begin
      bad++;
      $display("FAIL %s accept: rdy/busy/done got=%b want=100", name, {instr_ready, busy, done});
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    op_code = 3'($urandom);
    vlen = 4'($urandom);
    for (int cyc = 1; cyc <= 64 && done_cyc < 0; cyc++) begin
      fin = !(legal && elems <= int'(vl));
      if (!fin) begin
        if (stall_at >= 0) s = (elems == stall_at) && (stall_cnt < stall_len);
        else s = ($urandom_range(0, 99) < stall_pct);
      end else begin
        s = 1'($urandom);
      end
      stall = s;
      if (!fin) begin
        expv = {1'b0, 1'b1, 1'b0, 1'b0, (s ? {3'b000, c[2:0]} : c), 4'(elems)};
        mask = '1;
      end else begin
        expv = {1'b0, 1'b1, 1'b1, !legal, 6'b000000, 4'b0000};
        mask = {10'h3FF, 4'h0};
      end
      @(negedge clk);
      got = {instr_ready, busy, done, err, we_a_reg, we_b_reg, we_mem, mux0, mux1, mux2, elem_idx};
      total++;
      if ((got & mask) !== (expv & mask)) begin
        bad++;
        $display("FAIL %s cyc=%0d op=%0d vl=%0d got=%b want=%b", name, cyc, op, vl, got & mask, expv & mask);
      end
      wr_cnt += int'(we_a_reg) + int'(we_b_reg) + int'(we_mem);
      if (!fin) begin
        if (s) stall_cnt++;
        else elems++;
      end else begin
        done_cyc = cyc;
        if (legal) model_cnt++;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("FAIL %s timeout: no done within 64 cycles (want done)", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    op_code = '0;
    vlen = '0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    total++;
    if ({instr_ready, busy, done, err, we_a_reg, we_b_reg, we_mem, mux0, mux1, mux2, elem_idx} !== 14'b10000000000000) begin
      bad++;
      $display("FAIL reset outputs got=%b want=%b",
               {instr_ready, busy, done, err, we_a_reg, we_b_reg, we_mem, mux0, mux1, mux2, elem_idx},
               14'b10000000000000);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc, wc, sc;
    run_instr("basic", 3'd0, 4'd3, 0, -1, 0, dc, wc, sc);
    total++;
    if (dc != 5 || wc != 4) begin
      bad++;
      $display("FAIL basic latency/writes got=%0d/%0d want=5/4", dc, wc);
    end
  endtask

  task automatic test_stall();
    int dc, wc, sc;
    run_instr("stall", 3'd5, 4'd2, 0, 1, 2, dc, wc, sc);
    total++;
    if (dc != 6 || wc != 3) begin
      bad++;
      $display("FAIL stall latency/writes got=%0d/%0d want=6/3", dc, wc);
    end
  endtask

  task automatic test_illegal();
    int dc, wc, sc;
    run_instr("illegal", 3'd3, 4'($urandom), 0, -1, 0, dc, wc, sc);
    total++;
    if (dc != 1 || wc != 0) begin
      bad++;
      $display("FAIL illegal latency/writes got=%0d/%0d want=1/0", dc, wc);
    end
    run_instr("illegal2", 3'd2, 4'd9, 0, -1, 0, dc, wc, sc);
    total++;
    if (dc != 1 || wc != 0) begin
      bad++;
      $display("FAIL illegal2 latency/writes got=%0d/%0d want=1/0", dc, wc);
    end
  endtask

  task automatic test_max();
    int dc, wc, sc;
    run_instr("max", 3'd4, 4'd15, 0, -1, 0, dc, wc, sc);
    total++;
    if (dc != 17 || wc != 16) begin
      bad++;
      $display("FAIL max latency/writes got=%0d/%0d want=17/16", dc, wc);
    end
  endtask

  task automatic test_abort();
    int seen_done;
    instr_valid = 1'b1;
    op_code = 3'd7;
    vlen = 4'd7;
    stall = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (elem_idx !== 4'd2 || we_a_reg !== 1'b1) begin
      bad++;
      $display("FAIL abort pre idx/we_a got=%0d/%b want=2/1", elem_idx, we_a_reg);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    total++;
    if ({instr_ready, busy, done, err, we_a_reg, we_b_reg, we_mem, mux0, mux1, mux2, elem_idx} !== 14'b10000000000000) begin
      bad++;
      $display("FAIL abort post outputs got=%b want=%b",
               {instr_ready, busy, done, err, we_a_reg, we_b_reg, we_mem, mux0, mux1, mux2, elem_idx},
               14'b10000000000000);
    end
    seen_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    total++;
    if (seen_done != 0) begin
      bad++;
      $display("FAIL abort done pulses got=%0d want=0", seen_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int dc, wc, sc;
    run_instr("b2b_a", 3'd1, 4'd0, 0, -1, 0, dc, wc, sc);
    total++;
    if (dc != 2) begin
      bad++;
      $display("FAIL b2b_a latency got=%0d want=2", dc);
    end
    run_instr("b2b_b", 3'd6, 4'd0, 0, -1, 0, dc, wc, sc);
    total++;
    if (dc != 2) begin
      bad++;
      $display("FAIL b2b_b latency got=%0d want=2", dc);
    end
  endtask

  task automatic test_random();
    int dc, wc, sc, want;
    logic [2:0] op;
    logic [3:0] vl;
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom);
      vl = 4'($urandom);
      run_instr("random", op, vl, 30, -1, 0, dc, wc, sc);
      want = ref_legal(op) ? int'(vl) + 2 + sc : 1;
      total++;
      if (dc != want) begin
        bad++;
        $display("FAIL random latency op=%0d vl=%0d got=%0d want=%0d", op, vl, dc, want);
      end
    end
  endtask

`ifdef VSEQ_PERF_EN
  task automatic test_perf();
    int dc, wc, sc;
    run_instr("perf1", 3'd0, 4'd1, 0, -1, 0, dc, wc, sc);
    run_instr("perf2", 3'd2, 4'd1, 0, -1, 0, dc, wc, sc);
    run_instr("perf3", 3'd4, 4'd2, 0, -1, 0, dc, wc, sc);
    run_instr("perf4", 3'd5, 4'd0, 20, -1, 0, dc, wc, sc);
    @(negedge clk);
    total++;
    if (instr_count !== 16'd3) begin
      bad++;
      $display("FAIL perf count got=%0d want=3", instr_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_perf_total();
    @(negedge clk);
    total++;
    if (instr_count !== 16'(model_cnt)) begin
      bad++;
      $display("FAIL perf total got=%0d want=%0d", instr_count, model_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_illegal();
    test_max();
    test_abort();
`ifdef VSEQ_PERF_EN
    test_perf();
`endif
    test_back_to_back();
    test_random();
`ifdef VSEQ_PERF_EN
    test_perf_total();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
